// File: rtl/acc_result_buffer.sv
// acc_result_buffer
//   Result FIFO behind the sum-of-squares accumulator. Each accumulator
//   result (in_valid/in_data) is captured together with a wrap tag. Entries
//   are presented first-word-fall-through on a ready/valid port. The
//   accumulator cannot be stalled, so samples arriving while the FIFO is full
//   are dropped and counted (saturating at 255).
//
// Ports
//   clk, reset_n          : clock, async active-low reset
//   in_valid, in_data     : accumulator result strobe and value
//   out_ready             : consumer takes the head entry this cycle
//   out_valid, out_data   : FIFO non-empty, head data
//   out_overflow          : wrap tag stored with the head entry
//   full                  : FIFO holds DEPTH entries
//   drop_count            : samples lost to a full FIFO, saturating
module acc_result_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_overflow,
  output logic         full,
  output logic [7:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Each entry is {wrap_tag, data}.
  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  last_f;
  logic          wrapped;

  logic pop, push, wrap_now;

  assign out_valid    = (count != '0);
  assign full         = (count == DEPTH_C);
  assign out_data     = mem[rd_ptr][W-1:0];
  assign out_overflow = mem[rd_ptr][W];

  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = in_valid && ((count < DEPTH_C) || pop);
  // Accumulator output only decreases when it has wrapped mod 2^W.
  assign wrap_now = (in_data < last_f);

  // Storage needs no reset; only pointers/count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wrapped | wrap_now, in_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_f     <= '0;
      wrapped    <= 1'b0;
      drop_count <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // Wrap tracking follows every sample, including dropped ones.
      if (in_valid) begin
        last_f  <= in_data;
        wrapped <= wrapped | wrap_now;
      end

      if (in_valid && !push && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_acc_result_buffer.sv
// Scoreboard bench for acc_result_buffer: directed scenarios followed by
// randomized traffic. A queue-based model predicts accepted entries and their
// wrap tags; a negedge monitor compares the DUT head against the scoreboard.
module tb_acc_result_buffer;
  localparam int DEPTH = 4;
  localparam int W     = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         out_valid, out_overflow, full;
  logic [W-1:0] out_data;
  logic [7:0]   drop_count;

  acc_result_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_overflow(out_overflow), .full(full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed { logic [W-1:0] d; logic t; } ent_t;
  ent_t sb[$];

  // Reference model state: occupancy, previous sample, sticky wrap, drops.
  int           m_count;
  logic [W-1:0] m_last;
  logic         m_wr;
  int           m_drop;
  bit           m_pop, m_push, m_wn;
  ent_t         m_ent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is just a queue bounded at DEPTH entries.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      m_count = 0;
      m_last  = '0;
      m_wr    = 1'b0;
      m_drop  = 0;
    end else begin
      m_pop  = (m_count > 0) && out_ready;
      m_push = in_valid && ((m_count < DEPTH) || m_pop);
      if (in_valid) begin
        m_wn = (in_data < m_last);
        if (m_push) sb.push_back('{d: in_data, t: m_wr | m_wn});
        else if (m_drop < 255) m_drop++;
        m_wr   = m_wr | m_wn;
        m_last = in_data;
      end
      if (m_push) m_count++;
      if (m_pop)  m_count--;
    end
  end

  // Monitor: inputs only change just after posedge, so the negedge view of
  // out_ready is what the next posedge samples.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_count != 0});
      chk("full", {31'd0, full}, {31'd0, m_count == DEPTH});
      chk("drop_count", {24'd0, drop_count}, m_drop);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pop_empty_sb: got out_valid=1, want no entry pending (t=%0t)", $time);
        end else begin
          m_ent = sb.pop_front();
          chk("out_data", {12'd0, out_data}, {12'd0, m_ent.d});
          chk("out_overflow", {31'd0, out_overflow}, {31'd0, m_ent.t});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    in_valid = 1'b1; in_data = 20'd77;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_drop_count", {24'd0, drop_count}, 0);
    cyc(); cyc();
    in_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (m_count != 0 && k < 50) begin cyc(); k++; end
    if (m_count != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d entries left, want 0", m_count);
    end
    cyc();
    out_ready = 1'b0;
  endtask

  logic [W-1:0] cur;

  initial begin
    // 1. Reset at time zero, then mid-operation with 3 entries queued.
    #1;
    chk("rst0_out_valid", {31'd0, out_valid}, 0);
    chk("rst0_full", {31'd0, full}, 0);
    chk("rst0_drop_count", {24'd0, drop_count}, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    send(20'd1); send(20'd2); send(20'd3);
    do_reset();

    // 2. Pass-through with consumer always ready.
    out_ready = 1'b1;
    send(20'd441); send(20'd1737);
    cyc(); cyc();
    send(20'd5833);
    drain();

    // 3. Fill and drop.
    do_reset();
    send(20'd441); send(20'd1737); send(20'd5833); send(20'd6000);
    chk("fill_full", {31'd0, full}, 1);
    send(20'd7000);
    chk("fill_drop", {24'd0, drop_count}, 1);
    drain();
    chk("fill_empty", {31'd0, out_valid}, 0);

    // 4. Push and pop in the same cycle while full.
    do_reset();
    send(20'd10); send(20'd20); send(20'd30); send(20'd40);
    out_ready = 1'b1;
    send(20'd50);
    out_ready = 1'b0;
    chk("pp_full", {31'd0, full}, 1);
    chk("pp_drop", {24'd0, drop_count}, 0);
    drain();

    // 5. Wrap tagging, and tag cleared by reset.
    do_reset();
    out_ready = 1'b1;
    send(20'd1048000);
    chk("wrap_tag0", {31'd0, out_overflow}, 0);
    send(20'd100);
    send(20'd200);
    drain();
    do_reset();
    out_ready = 1'b1;
    send(20'd5);
    chk("wrap_after_rst", {31'd0, out_overflow}, 0);
    drain();

    // 6. Drop counter saturation with FIFO held full.
    do_reset();
    send(20'd11); send(20'd12); send(20'd13); send(20'd14);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = W'($urandom_range(0, 1048575));
      cyc();
    end
    in_valid = 1'b0;
    chk("drop_sat", {24'd0, drop_count}, 255);
    cyc();
    chk("drop_hold", {24'd0, drop_count}, 255);
    drain();

    // 7. Randomized traffic: mostly rising data with occasional wraps and
    //    phases of weak consumer readiness to provoke drops.
    do_reset();
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) cur = W'($urandom_range(0, 1000));
      else cur = cur + W'($urandom_range(0, 700));
      in_data = cur;
      if ((i / 200) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
      else                    out_ready = ($urandom_range(0, 3) == 0);
      cyc();
    end
    in_valid = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_result_buffer.md
# acc_result_buffer

Output buffer that sits directly downstream of the sum-of-squares accumulator. It captures each 20-bit accumulated result `f` when the accumulator pulses `valid_out`. It holds results in a small FIFO and presents them to a consumer over a ready/valid handshake. The accumulator has no backpressure, so the block also counts results lost while the FIFO is full and flags 20-bit accumulator wrap-around.

## Interface

Parameters:
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.
- `W`, 20: data width; matches the accumulator output.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: driven by accumulator `valid_out`; `in_data` is valid this cycle.
- `in_data`  in  W: accumulator `f`.
- `out_ready`  in  1: consumer accepts the head entry this cycle.
- `out_valid`  out  1: FIFO not empty.
- `out_data`  out  W: head entry data.
- `out_overflow`  out  1: wrap tag stored with the head entry.
- `full`  out  1: FIFO holds DEPTH entries.
- `drop_count`  out  8: number of samples dropped because the FIFO was full; saturates at 255.

## Operation

- Storage:
  - DEPTH x (W+1) register array holding data plus the overflow tag.
  - Read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter `count` of log2(DEPTH)+1 bits.
- Pop:
  - `pop = out_valid && out_ready`.
  - The read pointer advances on pop.
- Push:
  - `push = in_valid && (count < DEPTH || pop)`.
  - A full FIFO with a simultaneous pop accepts the new sample.
- Occupancy:
  - Push only: `count` increments.
  - Pop only: `count` decrements.
  - Push and pop together: `count` is unchanged.
- Drop:
  - A drop occurs when `in_valid && !push`.
  - `drop_count` increments by one per drop and holds at 255.
  - A dropped sample never alters FIFO contents.
- Wrap detection (the accumulator output is monotonically non-decreasing unless it wraps mod 2^W):
  - Register `last_f` (W bits) and sticky bit `wrapped`.
  - On every `in_valid`, whether the sample is pushed or dropped:
    - `wrap_now = (in_data < last_f)`, unsigned compare.
    - `last_f <= in_data`.
    - `wrapped <= wrapped | wrap_now`.
  - Stored tag for a pushed sample is `wrapped | wrap_now`.
  - Once set, every later entry is tagged 1 until reset.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_data` and `out_overflow` are read combinationally from the head entry (first-word fall-through).
  - `full = (count == DEPTH)`.
  - When `out_valid` is 0, `out_data` and `out_overflow` are don't-care.
- Consumer protocol: the consumer may hold `out_ready` high continuously. Asserting `out_ready` while `out_valid` is 0 has no effect.

## Timing

- Reset (`reset_n` low, asynchronous, immediate):
  - Pointers, `count`, `last_f`, `wrapped` and `drop_count` go to 0.
  - `out_valid`, `full` and `drop_count` read 0 without waiting for a clock edge.
  - Array contents need no reset.
- Reset release: the first rising edge with `reset_n` high is a normal cycle.
- Latency: a sample pushed at edge N appears as head, or queues behind older entries, immediately after edge N. An empty FIFO therefore shows `out_valid` 1 one cycle after `in_valid` is sampled.
- Ordering: strictly FIFO; no reordering or duplication.
- Back-to-back: accepts one `in_valid` per cycle indefinitely if `out_ready` stays high. Throughput is 1 entry/cycle.
- Full with no pop: incoming sample dropped; `full` stays 1.
- Empty with pop request: ignored; `count` stays 0.
- Reset mid-operation: all queued entries are lost. Any `in_valid` in the same cycle as reset is ignored.

## Test plan

1. Reset:
   - Stimulus: hold `reset_n` low for 2 cycles, then assert it low again asynchronously between edges while the FIFO holds 3 entries.
   - Response: `out_valid`, `full` and `drop_count` read 0 immediately both times.
2. Pass-through:
   - Stimulus: `out_ready` 1; `in_valid` pulses with 441, then 1737 on consecutive cycles, then 5833 three cycles later.
   - Response:
     - `out_valid` 1 the cycle after each push, with `out_data` 441, 1737, 5833 in order.
     - `out_overflow` 0 throughout.
     - `drop_count` 0.
3. Fill and drop:
   - Stimulus: `out_ready` 0; push 441, 1737, 5833, 6000, then 7000.
   - Response:
     - `full` is 1 after the 4th push.
     - 7000 is dropped and `drop_count` becomes 1.
     - Draining with `out_ready` 1 yields 441, 1737, 5833, 6000 and then `out_valid` 0.
4. Simultaneous push/pop at full:
   - Stimulus: fill with 10, 20, 30, 40; next cycle `in_valid` with 50 and `out_ready` 1.
   - Response:
     - `count` stays 4, `full` stays 1, `drop_count` unchanged.
     - Full drain yields 20, 30, 40, 50.
5. Wrap detection:
   - Stimulus: push 1048000, 100, 200, with `out_ready` 1.
   - Response:
     - Tags are 0, 1, 1.
     - After a reset, pushing 5 gives tag 0.
6. Drop saturation:
   - Stimulus: `out_ready` 0; FIFO full; 300 consecutive `in_valid` cycles.
   - Response: `drop_count` reaches 255 and holds; FIFO contents unchanged.
